// File: rtl/detect_sequence_param.sv
// detect_sequence_param: serial bit-pattern detector with runtime-loadable pattern, length and overlap mode
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   cfg_load     load cfg_pattern/cfg_len/cfg_overlap this cycle (rejected if cfg_len is 0 or > MAX_LEN)
//   cfg_pattern  pattern, bit [cfg_len-1] received first, bit [0] last
//   cfg_len      pattern length in bits
//   cfg_overlap  1 = overlapping matches counted, 0 = non-overlapping
//   en, a        serial input bit a, sampled only when en = 1
//   detected     one-cycle pulse the cycle after the last bit of a match
//   hit_count    saturating match counter
//   cfg_err      one-cycle pulse after a rejected cfg_load
module detect_sequence_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0011_0011,
  parameter int                 RST_LEN     = 6,
  parameter bit                 RST_OVERLAP = 1'b1,
  localparam int                LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               en,
  input  logic               a,
  output logic               detected,
  output logic [CNT_W-1:0]   hit_count,
  output logic               cfg_err
);
  typedef enum logic {FILL, ARMED} state_e;
  state_e             state_q;
  logic [MAX_LEN-1:0] pattern_q, hist_q, hist_d, mask;
  logic [LW-1:0]      len_q, fill_q;
  logic               ovl_q, det_q, err_q, match, cfg_ok;
  logic [CNT_W-1:0]   cnt_q;
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len_q);
    hist_d = {hist_q[MAX_LEN-2:0], a};
    cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
    // only the low len bits of history/pattern take part in the compare
    match = en && !cfg_load && (((hist_d ^ pattern_q) & mask) == '0) && (fill_q >= len_q - LW'(1));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= RST_PATTERN;
      len_q     <= LW'(RST_LEN);
      ovl_q     <= RST_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      state_q   <= FILL;
      det_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      det_q <= 1'b0;
      err_q <= 1'b0;
      if (cfg_load) begin
        if (cfg_ok) begin
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
          ovl_q     <= cfg_overlap;
          hist_q    <= '0;
          fill_q    <= '0;
          cnt_q     <= '0;
          state_q   <= FILL;
        end else begin
          err_q <= 1'b1;
        end
      end else if (en) begin
        hist_q <= hist_d;
        det_q  <= match;
        if (match && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        if (match && !ovl_q) begin
          fill_q  <= '0;
          state_q <= FILL;
        end else if (state_q == FILL) begin
          fill_q <= fill_q + LW'(1);
          if (fill_q + LW'(1) == len_q) state_q <= ARMED;
        end
      end
    end
  end
  assign detected  = det_q;
  assign hit_count = cnt_q;
  assign cfg_err   = err_q;
endmodule
